// File: rtl/vector_acc_multi_pkg.sv
// Shared defaults for the multi-lane vector accumulator and its RAM.
package vector_acc_multi_pkg;

  localparam int unsigned DEF_DIN_WIDTH     = 16;
  localparam int unsigned DEF_DOUT_WIDTH    = 32;
  localparam int unsigned DEF_VECTOR_LEN    = 64;
  localparam int unsigned DEF_N_CHANNELS    = 4;
  localparam int unsigned DEF_ACC_LEN_WIDTH = 16;
  localparam bit          DEF_IS_SIGNED     = 1'b1;

endpackage

// File: rtl/vector_acc_multi_bram.sv
// Simple dual-port inferred block RAM, one write and one registered read port.
module vector_acc_multi_bram
  import vector_acc_multi_pkg::*;
#(
  parameter int unsigned N_ADDR     = DEF_VECTOR_LEN,
  parameter int unsigned DATA_WIDTH = 8,
  localparam int unsigned AW        = $clog2(N_ADDR)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  // Storage and read register carry no reset so they map onto block RAM.
  logic [DATA_WIDTH-1:0] mem_q [N_ADDR];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rd_data_q <= mem_q[raddr];
  end

  assign rdata = rd_data_q;

endmodule

// File: rtl/vector_acc_multi.sv
// Multi-lane runtime-length vector accumulator with saturation, resync and
// a two-stage read-modify-write pipeline around one shared block RAM.
module vector_acc_multi
  import vector_acc_multi_pkg::*;
#(
  parameter int unsigned DIN_WIDTH     = DEF_DIN_WIDTH,
  parameter int unsigned DOUT_WIDTH    = DEF_DOUT_WIDTH,
  parameter int unsigned VECTOR_LEN    = DEF_VECTOR_LEN,
  parameter int unsigned N_CHANNELS    = DEF_N_CHANNELS,
  parameter bit          IS_SIGNED     = DEF_IS_SIGNED,
  parameter int unsigned ACC_LEN_WIDTH = DEF_ACC_LEN_WIDTH,
  localparam int unsigned IDX_W        = $clog2(VECTOR_LEN)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             sync,
  input  logic [ACC_LEN_WIDTH-1:0]         acc_len,
  input  logic [N_CHANNELS*DIN_WIDTH-1:0]  din,
  input  logic                             din_valid,
  output logic [N_CHANNELS*DOUT_WIDTH-1:0] dout,
  output logic                             dout_valid,
  output logic [IDX_W-1:0]                 dout_index,
  output logic                             dout_last,
  output logic [N_CHANNELS-1:0]            dout_sat
);

  localparam int unsigned WORD_W = DOUT_WIDTH + 1;
  localparam int unsigned SUM_W  = DOUT_WIDTH + 1;
  localparam int unsigned RAM_W  = N_CHANNELS * WORD_W;
  localparam int unsigned DIN_W  = N_CHANNELS * DIN_WIDTH;
  localparam int unsigned DOUT_W = N_CHANNELS * DOUT_WIDTH;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VECTOR_LEN - 1);

  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [ACC_LEN_WIDTH-1:0] vec_q, vec_d;
  logic [ACC_LEN_WIDTH-1:0] len_q, len_d;

  logic                     s0_sync, s0_wrap, s0_first, s0_last;
  logic [IDX_W-1:0]         s0_idx;
  logic [ACC_LEN_WIDTH-1:0] s0_vec, s0_len, len_in;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_first_q, s1_first_d;
  logic             s1_last_q, s1_last_d;
  logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
  logic [DIN_W-1:0] s1_din_q, s1_din_d;

  logic [RAM_W-1:0]      rd_data, wr_data;
  logic [DOUT_W-1:0]     sum_all;
  logic [N_CHANNELS-1:0] sat_all;

  logic [DOUT_W-1:0]     dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic [IDX_W-1:0]      dout_index_q, dout_index_d;
  logic                  dout_last_q, dout_last_d;
  logic [N_CHANNELS-1:0] dout_sat_q, dout_sat_d;

  // Stage 0: resolve this sample's index/vector position and advance counters.
  always_comb begin
    s0_sync  = sync & din_valid;
    len_in   = (acc_len == '0) ? ACC_LEN_WIDTH'(1) : acc_len;
    s0_idx   = s0_sync ? '0 : idx_q;
    s0_vec   = s0_sync ? '0 : vec_q;
    s0_len   = s0_sync ? len_in : len_q;
    s0_wrap  = (s0_idx == IDX_LAST);
    s0_first = (s0_vec == '0);
    s0_last  = (s0_vec == ACC_LEN_WIDTH'(s0_len - ACC_LEN_WIDTH'(1)));

    idx_d = idx_q;
    vec_d = vec_q;
    len_d = len_q;
    if (din_valid) begin
      idx_d = IDX_W'(s0_idx + IDX_W'(1));
      vec_d = s0_vec;
      len_d = s0_len;
      if (s0_wrap) begin
        if (s0_last) begin
          vec_d = '0;
          len_d = len_in;
        end else begin
          vec_d = ACC_LEN_WIDTH'(s0_vec + ACC_LEN_WIDTH'(1));
        end
      end
    end
  end

  always_comb begin
    s1_valid_d = din_valid;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    s1_idx_d   = s1_idx_q;
    s1_din_d   = s1_din_q;
    if (din_valid) begin
      s1_first_d = s0_first;
      s1_last_d  = s0_last;
      s1_idx_d   = s0_idx;
      s1_din_d   = din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      vec_q      <= '0;
      len_q      <= ACC_LEN_WIDTH'(1);
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_idx_q   <= '0;
      s1_din_q   <= '0;
    end else begin
      idx_q      <= idx_d;
      vec_q      <= vec_d;
      len_q      <= len_d;
      s1_valid_q <= s1_valid_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      s1_idx_q   <= s1_idx_d;
      s1_din_q   <= s1_din_d;
    end
  end

  vector_acc_multi_bram #(
    .N_ADDR     (VECTOR_LEN),
    .DATA_WIDTH (RAM_W)
  ) u_bram (
    .clk   (clk),
    .we    (s1_valid_q),
    .waddr (s1_idx_q),
    .wdata (wr_data),
    .re    (din_valid),
    .raddr (s0_idx),
    .rdata (rd_data)
  );

  // Stage 1: per-lane extend, add at one extra bit, clamp, and keep sticky flag.
  for (genvar k = 0; k < N_CHANNELS; k++) begin : g_lane
    logic [DIN_WIDTH-1:0]  din_k;
    logic [DOUT_WIDTH-1:0] acc_k, ext_k, clamp_k;
    logic [SUM_W-1:0]      sum_k;
    logic                  sat_in_k, ovf_k;
    logic [DOUT_WIDTH-1:0] res_k;
    logic                  sat_k;

    assign din_k    = s1_din_q[k*DIN_WIDTH +: DIN_WIDTH];
    assign acc_k    = rd_data[k*WORD_W +: DOUT_WIDTH];
    assign sat_in_k = rd_data[k*WORD_W + DOUT_WIDTH];

    if (IS_SIGNED) begin : g_signed
      assign ext_k   = DOUT_WIDTH'($signed(din_k));
      assign sum_k   = SUM_W'($signed(acc_k)) + SUM_W'($signed(ext_k));
      assign ovf_k   = sum_k[DOUT_WIDTH] ^ sum_k[DOUT_WIDTH-1];
      assign clamp_k = sum_k[DOUT_WIDTH] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                                         : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
    end else begin : g_unsigned
      assign ext_k   = DOUT_WIDTH'(din_k);
      assign sum_k   = SUM_W'(acc_k) + SUM_W'(ext_k);
      assign ovf_k   = sum_k[DOUT_WIDTH];
      assign clamp_k = '1;
    end

    // First vector overwrites: stale RAM contents and flags never leak in.
    always_comb begin
      res_k = sum_k[DOUT_WIDTH-1:0];
      sat_k = sat_in_k | ovf_k;
      if (s1_first_q) begin
        res_k = ext_k;
        sat_k = 1'b0;
      end else if (ovf_k) begin
        res_k = clamp_k;
      end
    end

    assign wr_data[k*WORD_W +: WORD_W]       = {sat_k, res_k};
    assign sum_all[k*DOUT_WIDTH +: DOUT_WIDTH] = res_k;
    assign sat_all[k]                         = sat_k;
  end

  always_comb begin
    dout_valid_d = 1'b0;
    dout_d       = dout_q;
    dout_index_d = dout_index_q;
    dout_last_d  = dout_last_q;
    dout_sat_d   = dout_sat_q;
    if (s1_valid_q && s1_last_q) begin
      dout_valid_d = 1'b1;
      dout_d       = sum_all;
      dout_index_d = s1_idx_q;
      dout_last_d  = (s1_idx_q == IDX_LAST);
      dout_sat_d   = sat_all;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_index_q <= '0;
      dout_last_q  <= 1'b0;
      dout_sat_q   <= '0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_index_q <= dout_index_d;
      dout_last_q  <= dout_last_d;
      dout_sat_q   <= dout_sat_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_index = dout_index_q;
  assign dout_last  = dout_last_q;
  assign dout_sat   = dout_sat_q;

endmodule

// File: tb/tb_vector_acc_multi.sv
// Randomised and directed bench: signed and unsigned instances share stimulus
// and are checked every cycle against an integer model of the accumulator.
module tb_vector_acc_multi;

  localparam int unsigned VL = 8;
  localparam int unsigned NC = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned OW = 10;
  localparam int unsigned LW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sync;
  logic [LW-1:0] acc_len;
  logic [15:0]   din;
  logic          din_valid;

  logic [19:0] dout_s, dout_u;
  logic        dv_s, dv_u;
  logic [2:0]  di_s, di_u;
  logic        dl_s, dl_u;
  logic [1:0]  ds_s, ds_u;

  always #5 clk = ~clk;

  vector_acc_multi #(
    .DIN_WIDTH(DW), .DOUT_WIDTH(OW), .VECTOR_LEN(VL), .N_CHANNELS(NC),
    .IS_SIGNED(1'b1), .ACC_LEN_WIDTH(LW)
  ) u_sgn (
    .clk(clk), .rst_n(rst_n), .sync(sync), .acc_len(acc_len), .din(din),
    .din_valid(din_valid), .dout(dout_s), .dout_valid(dv_s),
    .dout_index(di_s), .dout_last(dl_s), .dout_sat(ds_s)
  );

  vector_acc_multi #(
    .DIN_WIDTH(DW), .DOUT_WIDTH(OW), .VECTOR_LEN(VL), .N_CHANNELS(NC),
    .IS_SIGNED(1'b0), .ACC_LEN_WIDTH(LW)
  ) u_uns (
    .clk(clk), .rst_n(rst_n), .sync(sync), .acc_len(acc_len), .din(din),
    .din_valid(din_valid), .dout(dout_u), .dout_valid(dv_u),
    .dout_index(di_u), .dout_last(dl_u), .dout_sat(ds_u)
  );

  typedef struct {
    int          due;
    logic [2:0]  idx;
    logic        last;
    logic [19:0] ds;
    logic [1:0]  ss;
    logic [19:0] du;
    logic [1:0]  su;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   cnt_out = 0;

  int m_idx, m_vec, m_len;
  int acc_s[VL][NC];
  int acc_u[VL][NC];
  bit st_s[VL][NC];
  bit st_u[VL][NC];
  logic [19:0] hold_s, hold_u;

  logic [19:0] cap_s[VL];
  logic [19:0] cap_u[VL];
  logic [1:0]  cap_ss[VL];
  logic [1:0]  cap_us[VL];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, exp_v);
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    m_idx  = 0;
    m_vec  = 0;
    m_len  = 1;
    hold_s = '0;
    hold_u = '0;
  endfunction

  // One accepted sample, applied to the element-wise integer sums.
  function automatic void model_step(bit s, logic [LW-1:0] len, logic [7:0] d0, logic [7:0] d1);
    int   sidx, svec, slen, len1, t;
    logic [7:0] dk;
    exp_t e;
    len1 = (len == 0) ? 1 : int'(len);
    sidx = s ? 0 : m_idx;
    svec = s ? 0 : m_vec;
    slen = s ? len1 : m_len;
    for (int k = 0; k < NC; k++) begin
      dk = (k == 0) ? d0 : d1;
      if (svec == 0) begin
        acc_s[sidx][k] = int'($signed(dk));
        acc_u[sidx][k] = int'(dk);
        st_s[sidx][k]  = 1'b0;
        st_u[sidx][k]  = 1'b0;
      end else begin
        t = acc_s[sidx][k] + int'($signed(dk));
        if (t > 511) begin t = 511; st_s[sidx][k] = 1'b1; end
        if (t < -512) begin t = -512; st_s[sidx][k] = 1'b1; end
        acc_s[sidx][k] = t;
        t = acc_u[sidx][k] + int'(dk);
        if (t > 1023) begin t = 1023; st_u[sidx][k] = 1'b1; end
        acc_u[sidx][k] = t;
      end
    end
    if (svec == slen - 1) begin
      e.due  = cyc + 2;
      e.idx  = 3'(sidx);
      e.last = (sidx == VL - 1);
      for (int k = 0; k < NC; k++) begin
        e.ds[k*OW +: OW] = OW'(acc_s[sidx][k]);
        e.du[k*OW +: OW] = OW'(acc_u[sidx][k]);
        e.ss[k]          = st_s[sidx][k];
        e.su[k]          = st_u[sidx][k];
      end
      q.push_back(e);
    end
    m_idx = (sidx + 1) % VL;
    m_vec = svec;
    m_len = slen;
    if (sidx == VL - 1) begin
      if (svec == slen - 1) begin
        m_vec = 0;
        m_len = len1;
      end else begin
        m_vec = svec + 1;
      end
    end
  endfunction

  // Per-cycle compare of both instances against the model queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_dout_s", 32'(dout_s), 32'd0);
      chk("rst_valid_s", 32'(dv_s), 32'd0);
      chk("rst_dout_u", 32'(dout_u), 32'd0);
      chk("rst_flags", {25'd0, di_s, dl_s, ds_s, dv_u}, 32'd0);
    end else begin
      automatic bit   ev = (q.size() != 0) && (q[0].due == cyc);
      automatic exp_t e;
      chk("valid_s", 32'(dv_s), 32'(ev));
      chk("valid_u", 32'(dv_u), 32'(ev));
      if (ev) begin
        e = q.pop_front();
        chk("dout_s", 32'(dout_s), 32'(e.ds));
        chk("dout_u", 32'(dout_u), 32'(e.du));
        chk("index_s", 32'(di_s), 32'(e.idx));
        chk("index_u", 32'(di_u), 32'(e.idx));
        chk("last_s", 32'(dl_s), 32'(e.last));
        chk("last_u", 32'(dl_u), 32'(e.last));
        chk("sat_s", 32'(ds_s), 32'(e.ss));
        chk("sat_u", 32'(ds_u), 32'(e.su));
        hold_s = e.ds;
        hold_u = e.du;
      end else begin
        chk("hold_s", 32'(dout_s), 32'(hold_s));
        chk("hold_u", 32'(dout_u), 32'(hold_u));
      end
      if (dv_s) begin
        cap_s[di_s]  = dout_s;
        cap_u[di_s]  = dout_u;
        cap_ss[di_s] = ds_s;
        cap_us[di_s] = ds_u;
        cnt_out++;
      end
    end
  end

  task automatic step(bit v, bit s, logic [LW-1:0] len, logic [7:0] d0, logic [7:0] d1);
    @(posedge clk);
    #1;
    din_valid = v;
    sync      = s & v;
    acc_len   = len;
    din       = {d1, d0};
    if (v) model_step(s, len, d0, d1);
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 1'b0, acc_len, 8'd0, 8'd0);
  endtask

  task automatic run_const(logic [LW-1:0] len, logic [7:0] d, int n);
    for (int i = 0; i < n; i++) step(1'b1, i == 0, len, d, d);
    idle(4);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    din_valid = 1'b0;
    sync      = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("lit_rst_dout", 32'(dout_s), 32'd0);
    chk("lit_rst_valid", 32'(dv_s), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b1;
    sync      = 1'b0;
    acc_len   = 16'd1;
    din       = '0;
    din_valid = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    do_reset();
    idle(2);

    // Signed accumulate: lane0 = index, lane1 = -2, three vectors.
    cnt_out = 0;
    for (int i = 0; i < 24; i++) step(1'b1, i == 0, 16'd3, 8'(i % VL), 8'hFE);
    idle(4);
    chk("lit_acc_count", 32'(cnt_out), 32'd8);
    for (int i = 0; i < VL; i++) begin
      chk("lit_acc_l0", 32'(cap_s[i][9:0]), 32'(3 * i));
      chk("lit_acc_l1", 32'(cap_s[i][19:10]), 32'h3FA);
      chk("lit_acc_u1", 32'(cap_u[i][19:10]), 32'd762);
    end

    // Gappy valid, all ones, four vectors.
    cnt_out = 0;
    begin
      int n;
      bit v;
      n = 0;
      while (n < 32) begin
        v = 1'($urandom_range(0, 1));
        step(v, v && (n == 0), 16'd4, 8'd1, 8'd1);
        if (v) n++;
      end
    end
    idle(4);
    chk("lit_gap_count", 32'(cnt_out), 32'd8);
    chk("lit_gap_val", 32'(cap_s[5]), 32'h01004);

    // Saturation positive, negative, then clean integration.
    run_const(16'd8, 8'd127, 64);
    chk("lit_satp_val", 32'(cap_s[2]), {12'd0, 10'h1FF, 10'h1FF});
    chk("lit_satp_flag", 32'(cap_ss[2]), 32'd3);
    chk("lit_satp_u", 32'(cap_u[2][9:0]), 32'd1016);
    chk("lit_satp_uflag", 32'(cap_us[2]), 32'd0);
    run_const(16'd8, 8'h80, 64);
    chk("lit_satn_val", 32'(cap_s[6][9:0]), 32'h200);
    chk("lit_satn_flag", 32'(cap_ss[6]), 32'd3);
    chk("lit_satn_u", 32'(cap_u[6][9:0]), 32'd1023);
    run_const(16'd8, 8'd1, 64);
    chk("lit_clean_val", 32'(cap_s[0][9:0]), 32'd8);
    chk("lit_clean_flag", 32'(cap_ss[0]), 32'd0);

    // Unsigned mode: 0xFF twice, no sign extension.
    run_const(16'd2, 8'hFF, 16);
    chk("lit_uns_val", 32'(cap_u[3][9:0]), 32'd510);
    chk("lit_uns_sgn", 32'(cap_s[3][9:0]), 32'h3FE);

    // Resync at vector 2 index 5 discards the old integration.
    cnt_out = 0;
    for (int i = 0; i < 21; i++) step(1'b1, i == 0, 16'd4, 8'd2, 8'd2);
    chk("lit_resync_none", 32'(cnt_out), 32'd0);
    for (int i = 0; i < 32; i++) step(1'b1, i == 0, 16'd4, 8'd2, 8'd2);
    idle(4);
    chk("lit_resync_count", 32'(cnt_out), 32'd8);
    chk("lit_resync_val", 32'(cap_s[0][9:0]), 32'd8);

    // acc_len 3 -> 1 mid-integration takes effect after the current dump.
    cnt_out = 0;
    for (int i = 0; i < 8; i++) step(1'b1, i == 0, 16'd3, 8'd1, 8'd1);
    for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 16'd1, 8'd1, 8'd1);
    idle(4);
    chk("lit_len_count", 32'(cnt_out), 32'd24);
    chk("lit_len_val", 32'(cap_s[4][9:0]), 32'd1);

    // Reset mid-vector, then a clean integration.
    for (int i = 0; i < 5; i++) step(1'b1, i == 0, 16'd2, 8'd9, 8'd9);
    do_reset();
    run_const(16'd2, 8'd3, 16);
    chk("lit_post_rst", 32'(cap_s[7][9:0]), 32'd6);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0),
           LW'($urandom_range(0, 4)), 8'($urandom), 8'($urandom));
    end
    idle(4);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
